// File: rtl/axi_rd_pkg.sv
// Shared types for the AXI4 burst read responder: burst/response codes,
// controller states, the output beat record and the burst address stepper.
package axi_rd_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BURST = 2'b01,
        ST_DRAIN = 2'b10
    } state_e;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    // Next byte address of a burst; WRAP stays inside the (len+1)*step window.
    function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                              input logic [1:0]  burst,
                                              input logic [7:0]  len,
                                              input logic [2:0]  size);
        logic [31:0] step;
        logic [31:0] mask;
        step = 32'd1 << size;
        mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~mask) | ((addr + step) & mask);
            default:     next_addr = addr + step;
        endcase
    endfunction

endpackage

// File: rtl/axi_burst_rd_slave_if.sv
// AXI4 read address and read data channels (AR + R).
interface axi_burst_rd_slave_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic [1:0]  arburst;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rlast;
    logic        rready;

    modport master (
        output araddr, arvalid, arburst, arlen, arsize, rready,
        input  arready, rdata, rresp, rvalid, rlast
    );

    modport slave (
        input  araddr, arvalid, arburst, arlen, arsize, rready,
        output arready, rdata, rresp, rvalid, rlast
    );
endinterface

// File: rtl/rd_out_fifo.sv
// Small synchronous FIFO of read beats; the head reads as zero when empty so
// the R channel shows clean values outside of valid beats.
module rd_out_fifo
    import axi_rd_pkg::*;
#(
    parameter int OUT_DEPTH = 2
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_push,
    input  beat_t                              i_push_beat,
    input  logic                               i_pop,
    output logic [$clog2(OUT_DEPTH + 1) - 1:0] o_count,
    output beat_t                              o_head
);
    localparam int CW = $clog2(OUT_DEPTH + 1);
    localparam int PW = $clog2(OUT_DEPTH);

    beat_t           r_mem [OUT_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Beat storage; contents are only observed through the gated head.
    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_push_beat;
    end

    // Pointers and occupancy.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= bump(r_wr_ptr);
            if (i_pop)  r_rd_ptr <= bump(r_rd_ptr);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_count = r_count;
    assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
endmodule

// File: rtl/axi_burst_rd_slave.sv
// AXI4 burst read responder backed by a synchronous 64-bit SRAM.
// state  | meaning
// IDLE   | arready high, waiting for a read request
// BURST  | issuing beats (SRAM reads or error beats) under FIFO credit
// DRAIN  | all beats issued, waiting for the rlast handshake
module axi_burst_rd_slave
    import axi_rd_pkg::*;
#(
    parameter logic [31:0] MEM_BASE  = 32'h8000_0000,
    parameter int          MEM_WORDS = 4096,
    parameter int          ADDR_W    = 12,
    parameter int          OUT_DEPTH = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    axi_burst_rd_slave_if.slave s_axi,
    output logic                o_mem_ren,
    output logic [ADDR_W-1:0]   o_mem_addr,
    input  logic [63:0]         i_mem_rdata
);
    localparam int          CW        = $clog2(OUT_DEPTH + 1);
    localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS) << 3;

    function automatic logic in_range(input logic [31:0] a);
        return (a >= MEM_BASE) && ((a - MEM_BASE) < MEM_BYTES);
    endfunction

    state_e        r_state;
    state_e        w_next_state;
    logic          r_arready;
    logic [31:0]   r_addr;
    logic [1:0]    r_burst;
    logic [7:0]    r_len;
    logic [2:0]    r_size;
    logic [1:0]    r_err;
    logic [8:0]    r_issue_cnt;
    logic          r_infl;
    logic [1:0]    r_infl_resp;
    logic          r_infl_last;

    logic          w_accept;
    logic          w_rvalid;
    logic          w_pop;
    logic          w_issue;
    logic          w_credit;
    logic [1:0]    w_req_err;
    logic [1:0]    w_beat_resp;
    logic [CW:0]   w_occ;
    logic [CW:0]   w_lim;
    logic [CW-1:0] w_count;
    beat_t         w_head;
    beat_t         w_push_beat;

    assign w_accept = r_arready & s_axi.arvalid;
    assign w_rvalid = (w_count != '0);
    assign w_pop    = w_rvalid & s_axi.rready;

    // Slots already spoken for (queued + in flight) must fit after this cycle's pop.
    assign w_occ    = {1'b0, w_count} + {{CW{1'b0}}, r_infl};
    assign w_lim    = (CW + 1)'(OUT_DEPTH) + {{CW{1'b0}}, w_pop};
    assign w_credit = (w_occ < w_lim);

    // Whole-request classification at acceptance, and per-beat response.
    always_comb begin
        w_req_err = RESP_OKAY;
        if (!in_range(s_axi.araddr)) begin
            w_req_err = RESP_DECERR;
        end else if ((s_axi.arsize > 3'd3) || (s_axi.arburst == BURST_RSVD) ||
                     ((s_axi.arburst == BURST_WRAP) &&
                      !(s_axi.arlen inside {8'd1, 8'd3, 8'd7, 8'd15}))) begin
            w_req_err = RESP_SLVERR;
        end
        w_beat_resp = r_err;
        if ((r_err == RESP_OKAY) && !in_range(r_addr)) w_beat_resp = RESP_DECERR;
    end

    // Next-state and issue decision.
    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next_state = ST_BURST;
            end
            ST_BURST: begin
                w_issue = (r_issue_cnt <= {1'b0, r_len}) && w_credit;
                if (w_issue && (r_issue_cnt == {1'b0, r_len})) w_next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_pop && w_head.last) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
        o_mem_ren = w_issue && (w_beat_resp == RESP_OKAY);
    end

    assign o_mem_addr = ADDR_W'((r_addr - MEM_BASE) >> 3);

    // State register; arready is registered and follows the IDLE state.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state   <= ST_IDLE;
            r_arready <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_arready <= (w_next_state == ST_IDLE);
        end
    end

    // Request capture and address/issue counter stepping.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_addr      <= '0;
            r_burst     <= '0;
            r_len       <= '0;
            r_size      <= '0;
            r_err       <= '0;
            r_issue_cnt <= '0;
        end else if (w_accept) begin
            r_addr      <= s_axi.araddr;
            r_burst     <= s_axi.arburst;
            r_len       <= s_axi.arlen;
            r_size      <= s_axi.arsize;
            r_err       <= w_req_err;
            r_issue_cnt <= '0;
        end else if (w_issue) begin
            r_addr      <= next_addr(r_addr, r_burst, r_len, r_size);
            r_issue_cnt <= r_issue_cnt + 9'd1;
        end
    end

    // One-cycle issue pipeline matching the SRAM read latency.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_infl      <= 1'b0;
            r_infl_resp <= '0;
            r_infl_last <= 1'b0;
        end else begin
            r_infl      <= w_issue;
            r_infl_resp <= w_beat_resp;
            r_infl_last <= (r_issue_cnt[7:0] == r_len);
        end
    end

    // Error beats carry zero data.
    always_comb begin
        w_push_beat.data = (r_infl_resp == RESP_OKAY) ? i_mem_rdata : 64'd0;
        w_push_beat.resp = r_infl_resp;
        w_push_beat.last = r_infl_last;
    end

    rd_out_fifo #(.OUT_DEPTH(OUT_DEPTH)) u_out_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (r_infl),
        .i_push_beat (w_push_beat),
        .i_pop       (w_pop),
        .o_count     (w_count),
        .o_head      (w_head)
    );

    assign s_axi.arready = r_arready;
    assign s_axi.rvalid  = w_rvalid;
    assign s_axi.rdata   = w_head.data;
    assign s_axi.rresp   = w_head.resp;
    assign s_axi.rlast   = w_head.last;
endmodule
